stream_sram_writer: RTL

Sink-side counterpart of the stream processing unit: accepts the SPU result stream (`m_data0`/`m_data1`/`m_valid`, no backpressure) and writes each valid beat as one `2*DATA_BITS` word into an SRAM write port at consecutive addresses. It sits between the last SPU stage and the destination SRAM of the SRAM-to-SRAM evaluation path. Software-style control (`start`, base address, beat count) frames one transfer; `busy`/`done`/`overflow` report status.

---
 rtl/stream_sram_pkg.sv | 24 ++
 rtl/stream_sram_addr_counter.sv | 46 ++++
 rtl/stream_sram_writer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/stream_sram_pkg.sv
// Shared types for the stream <-> SRAM movers (writer now, reader later).
package stream_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Packages cannot take parameters, so this is the 64-bit lane layout.
  // Modules built with another lane width declare the same {data1, data0} shape locally.
  localparam int unsigned LANE_BITS = 64;

  typedef struct packed {
    logic [LANE_BITS-1:0] data1;
    logic [LANE_BITS-1:0] data0;
  } word_t;

  // DONE is a parked IDLE that also carries status.
  function automatic logic can_start(input state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/stream_sram_addr_counter.sv
// Loadable wrapping word-address counter with a beats-remaining count.
// last_o flags the beat that finishes the transfer.
module stream_sram_addr_counter #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cke_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [ADDR_BITS-1:0] base_i,
  input  logic [ADDR_BITS-1:0] len_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 last_o
);

  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] remain_q, remain_d;

  // The address wraps modulo 2^ADDR_BITS with no flag.
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = base_i;
      remain_d = len_i;
    end else if (step_i) begin
      addr_d   = addr_q + 1'b1;
      remain_d = remain_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (cke_i) begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remain_q == ADDR_BITS'(1));

endmodule

// File: rtl/stream_sram_writer.sv
// Writes each valid SPU result beat as one {data1, data0} word to consecutive SRAM addresses.
// Optional running XOR of written words: define STREAM_SRAM_WRITER_CHECKSUM_EN.
module stream_sram_writer
  import stream_sram_pkg::*;
#(
  parameter int    DATA_BITS  = 64,
  parameter int    ADDR_BITS  = 10,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,
  input  logic                   start,
  input  logic [ADDR_BITS-1:0]   base_addr,
  input  logic [ADDR_BITS-1:0]   length,
  input  logic [DATA_BITS-1:0]   s_data0,
  input  logic [DATA_BITS-1:0]   s_data1,
  input  logic                   s_valid,
  output logic                   sram_we,
  output logic [ADDR_BITS-1:0]   sram_addr,
  output logic [2*DATA_BITS-1:0] sram_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
`ifdef STREAM_SRAM_WRITER_CHECKSUM_EN
  ,
  output logic [2*DATA_BITS-1:0] checksum
`endif
);

  typedef struct packed {
    logic [DATA_BITS-1:0] data1;
    logic [DATA_BITS-1:0] data0;
  } beat_t;

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  beat_t                wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic                 accept, take, drop;
  logic [ADDR_BITS-1:0] cnt_addr;
  logic                 cnt_last;
  beat_t                beat_in;

  assign beat_in = '{data1: s_data1, data0: s_data0};
  assign accept  = start && can_start(state_q);
  assign take    = s_valid && (state_q == RUN);
  assign drop    = s_valid && (state_q != RUN);

  stream_sram_addr_counter #(
    .ADDR_BITS (ADDR_BITS)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .cke_i  (cke),
    .load_i (accept),
    .step_i (take),
    .base_i (base_addr),
    .len_i  (length),
    .addr_o (cnt_addr),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = (length != '0) ? RUN : DONE;
      RUN:        if (take && cnt_last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Address/data only move on a real beat; they are qualified by sram_we.
  always_comb begin
    we_d    = take;
    addr_d  = take ? cnt_addr : addr_q;
    wdata_d = take ? beat_in : wdata_q;
    done_d  = (take && cnt_last) || (accept && (length == '0));
    // A beat dropped in the same cycle as an accepted start still counts.
    ovf_d   = drop ? 1'b1 : (accept ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (cke) begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign overflow   = ovf_q;

`ifdef STREAM_SRAM_WRITER_CHECKSUM_EN
  logic [2*DATA_BITS-1:0] csum_q, csum_d;

  // Folds in at the same edge that registers the write, so it is final alongside done.
  always_comb begin
    csum_d = csum_q;
    if (accept)    csum_d = '0;
    else if (take) csum_d = csum_q ^ beat_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   csum_q <= '0;
    else if (cke) csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

  if ((SIMULATION == "true" || DEBUG == "true") && DEVICE != "") begin : g_chk
    always_ff @(posedge clk) begin
      if (reset && cke) assert (!(done_q && state_q == RUN));
    end
  end

endmodule
